// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external 1-cycle-latency RAM.
// Define FIFO_ERR_EN to build in the sticky overflow/underflow error flag.
module fifo_ctrl #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              error
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              vld_q;
  logic              push_acc;
  logic              pop_acc;

  // Requests are ignored while reset is held so no RAM write escapes.
  assign pop_acc  = reset_L & pop & ~empty;
  assign push_acc = reset_L & push & (~full | pop_acc);

  assign full         = (cnt == DEPTH);
  assign empty        = (cnt == '0);
  assign almost_full  = (af_thresh != '0) && (cnt >= af_thresh);
  assign almost_empty = (cnt <= ae_thresh);
  assign count        = cnt;

  assign mem_we    = push_acc;
  assign mem_waddr = wr_ptr;
  assign mem_wdata = data_in;
  assign mem_re    = pop_acc;
  assign mem_raddr = rd_ptr;

  assign data_out  = mem_rdata;
  assign valid_out = vld_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld_q  <= 1'b0;
    end else begin
      if (push_acc)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_acc)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      unique case ({push_acc, pop_acc})
        2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
        2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
        default: cnt <= cnt;
      endcase
      vld_q <= pop_acc;
    end
  end

`ifdef FIFO_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)
      err_q <= 1'b0;
    else if ((push & full & ~pop) | (pop & empty))
      err_q <= 1'b1;
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed testbench for fifo_ctrl with a behavioural 1-cycle RAM.
// Error expectations follow FIFO_ERR_EN.
module tb_fifo_ctrl;

  localparam int DW = 10;
  localparam int AW = 3;
`ifdef FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_L;
  logic          push, pop;
  logic [DW-1:0] data_in;
  logic [AW:0]   af_thresh, ae_thresh;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata, mem_rdata, data_out;
  logic          valid_out, full, empty, almost_full, almost_empty, error;
  logic [AW:0]   count;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    mem_rdata <= mem_re ? ram[mem_raddr] : '0;
  end

  fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop),
    .data_in(data_in), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .data_out(data_out), .valid_out(valid_out), .full(full),
    .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .error(error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push = 0; pop = 0; data_in = '0;
    reset_L = 0;
    step();
    reset_L = 1;
    step();
  endtask

  task automatic test_reset();
    push = 1; pop = 0; data_in = 10'h3FF;
    af_thresh = 4'd6; ae_thresh = 4'd1;
    reset_L = 0;
    step();
    step();
    checks++;
    if ({empty, full, almost_full, almost_empty} !== 4'b1001) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=1001",
               {empty, full, almost_full, almost_empty});
    end
    checks++;
    if (count !== 4'd0) begin
      errors++; $display("FAIL reset_count got=%0d exp=0", count);
    end
    checks++;
    if ({mem_we, valid_out, error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_we_vld_err got=%b exp=000",
               {mem_we, valid_out, error});
    end
    push = 0;
    reset_L = 1;
    step();
  endtask

  task automatic test_order();
    do_reset();
    push = 1; data_in = 10'h155;
    #1;
    checks++;
    if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 3'd0, 10'h155}) begin
      errors++;
      $display("FAIL order_wr0 got we=%b a=%0d d=%h exp 1/0/155",
               mem_we, mem_waddr, mem_wdata);
    end
    step();
    data_in = 10'h2AA;
    step();
    push = 0; pop = 1;
    #1;
    checks++;
    if ({count, mem_re, mem_raddr} !== {4'd2, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL order_rd0 got cnt=%0d re=%b a=%0d exp 2/1/0",
               count, mem_re, mem_raddr);
    end
    step();
    checks++;
    if ({valid_out, data_out} !== {1'b1, 10'h155}) begin
      errors++;
      $display("FAIL order_d0 got v=%b d=%h exp 1/155",
               valid_out, data_out);
    end
    step();
    pop = 0;
    checks++;
    if ({valid_out, data_out} !== {1'b1, 10'h2AA}) begin
      errors++;
      $display("FAIL order_d1 got v=%b d=%h exp 1/2aa",
               valid_out, data_out);
    end
    step();
    checks++;
    if ({valid_out, empty} !== 2'b01) begin
      errors++;
      $display("FAIL order_idle got v=%b e=%b exp 0/1",
               valid_out, empty);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    af_thresh = 4'd6;
    for (int i = 0; i < 8; i++) begin
      push = 1; data_in = DW'(10'h100 + i);
      step();
      checks++;
      if (almost_full !== (i >= 5)) begin
        errors++;
        $display("FAIL ovf_af%0d got=%b exp=%b", i, almost_full, i >= 5);
      end
    end
    checks++;
    if ({full, count} !== {1'b1, 4'd8}) begin
      errors++;
      $display("FAIL ovf_full got f=%b c=%0d exp 1/8", full, count);
    end
    data_in = 10'h0AB;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL ovf_we got=%b exp=0", mem_we);
    end
    step();
    push = 0;
    checks++;
    if ({count, error} !== {4'd8, ERR}) begin
      errors++;
      $display("FAIL ovf_cnt_err got c=%0d e=%b exp 8/%b",
               count, error, ERR);
    end
  endtask

  task automatic test_full_both();
    push = 1; pop = 1; data_in = 10'h3FF;
    #1;
    checks++;
    if ({mem_we, mem_re, mem_waddr, mem_raddr} !==
        {1'b1, 1'b1, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL both_ports got we=%b re=%b wa=%0d ra=%0d exp 1/1/0/0",
               mem_we, mem_re, mem_waddr, mem_raddr);
    end
    step();
    push = 0;
    checks++;
    if ({count, valid_out, data_out} !== {4'd8, 1'b1, 10'h100}) begin
      errors++;
      $display("FAIL both_data got c=%0d v=%b d=%h exp 8/1/100",
               count, valid_out, data_out);
    end
    for (int i = 1; i < 9; i++) begin
      step();
      checks++;
      if ({valid_out, data_out} !==
          {1'b1, (i == 8) ? 10'h3FF : DW'(10'h100 + i)}) begin
        errors++;
        $display("FAIL drain%0d got v=%b d=%h", i, valid_out, data_out);
      end
    end
    pop = 0;
    step();
    checks++;
    if ({empty, count} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL drain_empty got e=%b c=%0d exp 1/0", empty, count);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    pop = 1;
    #1;
    checks++;
    if (mem_re !== 1'b0) begin
      errors++; $display("FAIL unf_re got=%b exp=0", mem_re);
    end
    step();
    pop = 0;
    checks++;
    if ({valid_out, error, count} !== {1'b0, ERR, 4'd0}) begin
      errors++;
      $display("FAIL unf_state got v=%b e=%b c=%0d exp 0/%b/0",
               valid_out, error, count, ERR);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    ae_thresh = 4'd1;
    for (int i = 0; i < 12; i++) begin
      push = 1; pop = 0; data_in = DW'(i);
      #1;
      checks++;
      if (mem_waddr !== AW'(i % 8)) begin
        errors++;
        $display("FAIL wrap_wa%0d got=%0d exp=%0d", i, mem_waddr, i % 8);
      end
      step();
      push = 0; pop = 1;
      checks++;
      if (almost_empty !== 1'b1) begin
        errors++; $display("FAIL wrap_ae%0d got=%b exp=1", i, almost_empty);
      end
      step();
      pop = 0;
      checks++;
      if ({valid_out, data_out} !== {1'b1, DW'(i)}) begin
        errors++;
        $display("FAIL wrap_d%0d got v=%b d=%0d exp 1/%0d",
                 i, valid_out, data_out, i);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push = 1; data_in = DW'(10'h040 + i);
      step();
    end
    push = 0; pop = 1;
    step();
    pop = 0;
    #2;
    reset_L = 0;
    #1;
    checks++;
    if ({valid_out, count, empty} !== {1'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_async got v=%b c=%0d e=%b exp 0/0/1",
               valid_out, count, empty);
    end
    step();
    reset_L = 1;
    step();
    checks++;
    if ({valid_out, empty, error} !== 3'b010) begin
      errors++;
      $display("FAIL rstmid_after got v=%b e=%b err=%b exp 0/1/0",
               valid_out, empty, error);
    end
  endtask

  initial begin
    reset_L = 0; push = 0; pop = 0; data_in = '0;
    af_thresh = 4'd6; ae_thresh = 4'd1;
    #1;
    test_reset();
    test_order();
    test_overflow();
    test_full_both();
    test_underflow();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 10, giving the width of the data word.
REQ-002 The block SHALL have parameter ADDR_W, default 3, giving the address width; depth is 2**ADDR_W = 8 entries.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_L, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port push, input, 1 bit: write request.
REQ-006 The block SHALL have port pop, input, 1 bit: read request.
REQ-007 The block SHALL have port data_in, input, DATA_W bits: write data.
REQ-008 The block SHALL have ports af_thresh and ae_thresh, input, ADDR_W+1 bits each: almost-full and almost-empty thresholds.
REQ-009 The block SHALL have ports mem_we (out, 1), mem_waddr (out, ADDR_W) and mem_wdata (out, DATA_W): the RAM write port.
REQ-010 The block SHALL have ports mem_re (out, 1) and mem_raddr (out, ADDR_W): the RAM read request.
REQ-011 The block SHALL have port mem_rdata, input, DATA_W bits: registered RAM read data with 1-cycle latency, 0 when not read.
REQ-012 The block SHALL have ports data_out (out, DATA_W) and valid_out (out, 1): read data and its qualifier.
REQ-013 The block SHALL have ports full, empty, almost_full, almost_empty (out, 1 each), count (out, ADDR_W+1) and error (out, 1).

Function
REQ-014 push_acc SHALL be push AND (NOT full OR pop_acc); pop_acc SHALL be pop AND NOT empty.
- No write-through or bypass when empty.
REQ-015 mem_we SHALL equal push_acc combinationally, with mem_waddr = wr_ptr and mem_wdata = data_in.
REQ-016 mem_re SHALL equal pop_acc combinationally, with mem_raddr = rd_ptr.
REQ-017 wr_ptr SHALL increment modulo 2**ADDR_W on each push_acc, and rd_ptr SHALL increment modulo 2**ADDR_W on each pop_acc (wrap 7 -> 0).
REQ-018 count SHALL update as follows:
- +1 on push_acc only;
- -1 on pop_acc only;
- unchanged when both or neither occur;
- range 0..8.
REQ-019 Flags SHALL be decoded combinationally from the count register:
- full = (count == 8);
- empty = (count == 0);
- almost_full = (af_thresh != 0) AND (count >= af_thresh);
- almost_empty = (count <= ae_thresh).
REQ-020 valid_out SHALL be pop_acc delayed by one clk; data_out SHALL pass mem_rdata through unchanged.
- Read latency is 1 cycle from pop to data.
REQ-021 When full, a simultaneous push and pop SHALL both be accepted.
- The RAM returns the old entry at the shared address.
- count stays 8.
REQ-022 A rejected push or pop SHALL change no pointer, count or memory port.

Reset
REQ-023 While reset_L = 0, the block SHALL hold the following, asynchronously:
- wr_ptr = 0, rd_ptr = 0, count = 0;
- valid_out = 0, error = 0;
- empty = 1, full = 0, almost_full = 0;
- almost_empty = 1.
REQ-024 Reset asserted mid-operation SHALL discard all stored entries and any pending read.
- valid_out SHALL be 0 on the first cycle after release.

Configuration
REQ-025 When macro FIFO_ERR_EN is defined, a sticky error register SHALL be compiled in.
- It is set on overflow (push AND full AND NOT pop).
- It is set on underflow (pop AND empty).
- It is cleared only by reset_L.
REQ-026 When FIFO_ERR_EN is undefined, the error register SHALL be compiled out.
- error is tied to 0.
- All other behaviour is identical.

Verification
REQ-027 Reset check: drive reset_L = 0 with push = 1 -> empty = 1, count = 0, mem_we = 0, valid_out = 0, error = 0.
REQ-028 Ordering: push 10'h155 then 10'h2AA, then pop twice -> data_out = 10'h155 then 10'h2AA, each with valid_out = 1 one cycle after its pop.
REQ-029 Overflow: with af_thresh = 6, push 8 words -> almost_full rises after the 6th, full = 1 and count = 8 after the 8th.
- A 9th push gives mem_we = 0 and count = 8.
- error = 1 with FIFO_ERR_EN defined, 0 without.
REQ-030 Full simultaneous push and pop: count stays 8, and popped data is the oldest word.
REQ-031 Underflow: pop when empty -> mem_re = 0 and valid_out = 0 next cycle; error = 1 (FIFO_ERR_EN defined).
REQ-032 Wrap: 12 alternating push/pop pairs (data 0..11) -> pointers wrap 7 -> 0 and data_out returns 0..11 in order.
- ae_thresh = 1 keeps almost_empty = 1 throughout.
